// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - sequence-memory playback controller for the tone datapath
// Walks {rest, dur, note} entries on a tempo tick and gates the PWM output.
module tone_sequencer #(
  parameter int IDX_W   = 6,
  parameter int SEQ_LEN = 64,
  parameter int DUR_W   = 4,
  parameter int TICK_W  = 24,
  parameter int GAP_EN  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 pause_i,
  input  logic                 loop_i,
  input  logic [TICK_W-1:0]    tempo_i,
  output logic [IDX_W-1:0]     seq_addr_o,
  input  logic [DUR_W+IDX_W:0] seq_data_i,
  output logic [IDX_W-1:0]     note_index_o,
  output logic                 gate_o,
  output logic                 busy_o,
  output logic                 step_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, DONE} state_t;

  state_t              state;
  logic [IDX_W-1:0]    seq_addr;
  logic [IDX_W-1:0]    note_index;
  logic [DUR_W-1:0]    dur_cnt;
  logic                rest;
  logic [TICK_W-1:0]   tick_cnt;

  logic                fetch_rest;
  logic [DUR_W-1:0]    fetch_dur;
  logic [IDX_W-1:0]    fetch_note;
  logic                is_end;
  logic [TICK_W-1:0]   tick_max;
  logic                timing;
  logic                tick;
  logic                at_last;
  state_t              end_state;
  logic [IDX_W-1:0]    end_addr;
  state_t              adv_state;
  logic [IDX_W-1:0]    adv_addr;

  assign {fetch_rest, fetch_dur, fetch_note} = seq_data_i;
  assign is_end   = fetch_rest && (&fetch_note);
  assign tick_max = (tempo_i == '0) ? '0 : tempo_i - TICK_W'(1);
  assign timing   = ((state == PLAY) || (state == GAP)) && !pause_i;
  assign tick     = timing && (tick_cnt == tick_max);
  assign at_last  = (seq_addr == IDX_W'(SEQ_LEN - 1));

  // End of sequence either wraps to entry 0 or finishes; advance reuses it on the last entry.
  always_comb begin
    end_state = loop_i ? FETCH : DONE;
    end_addr  = loop_i ? '0 : seq_addr;
    adv_state = FETCH;
    adv_addr  = seq_addr + IDX_W'(1);
    if (at_last) begin
      adv_state = end_state;
      adv_addr  = end_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      seq_addr   <= '0;
      note_index <= '0;
      dur_cnt    <= '0;
      rest       <= 1'b0;
      tick_cnt   <= '0;
    end else if (stop_i) begin
      state    <= IDLE;
      seq_addr <= '0;
      tick_cnt <= '0;
    end else begin
      if (timing) begin
        tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= FETCH;
            seq_addr <= '0;
            tick_cnt <= '0;
          end
        end
        FETCH: begin
          note_index <= fetch_note;
          dur_cnt    <= fetch_dur;
          rest       <= fetch_rest;
          if (is_end) begin
            state    <= end_state;
            seq_addr <= end_addr;
          end else begin
            state <= PLAY;
          end
        end
        PLAY: begin
          if (tick) begin
            if (dur_cnt == '0) begin
              if (GAP_EN != 0) begin
                state <= GAP;
              end else begin
                state    <= adv_state;
                seq_addr <= adv_addr;
              end
            end else begin
              dur_cnt <= dur_cnt - DUR_W'(1);
            end
          end
        end
        GAP: begin
          if (tick) begin
            state    <= adv_state;
            seq_addr <= adv_addr;
          end
        end
        DONE: begin
          state    <= IDLE;
          seq_addr <= '0;
        end
        default: begin
          state    <= IDLE;
          seq_addr <= '0;
        end
      endcase
    end
  end

  assign seq_addr_o   = seq_addr;
  assign note_index_o = note_index;
  assign gate_o       = (state == PLAY) && !rest && !pause_i;
  assign busy_o       = (state != IDLE);
  assign step_o       = (state == FETCH);
  assign done_o       = (state == DONE);

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - self-checking bench for tone_sequencer
// Phase/remaining-clocks model checked every cycle, plus literal timeline checks.
module tb_tone_sequencer;

  localparam int IDX_W   = 6;
  localparam int SEQ_LEN = 4;
  localparam int DUR_W   = 4;
  localparam int TICK_W  = 24;
  localparam int GAP_EN  = 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start_i = 1'b0;
  logic                 stop_i = 1'b0;
  logic                 pause_i = 1'b0;
  logic                 loop_i = 1'b0;
  logic [TICK_W-1:0]    tempo_i = '0;
  logic [IDX_W-1:0]     seq_addr_o;
  logic [DUR_W+IDX_W:0] seq_data_i;
  logic [IDX_W-1:0]     note_index_o;
  logic                 gate_o, busy_o, step_o, done_o;

  logic [DUR_W+IDX_W:0] mem [SEQ_LEN];
  int tests = 0;
  int fails = 0;

  // Model: phase 0 idle, 1 fetch, 2 play, 3 gap, 4 done; m_left = clocks left in play/gap.
  int         m_phase = 0;
  logic [5:0] m_addr = '0;
  logic [5:0] m_note = '0;
  logic       m_rest = 1'b0;
  int         m_left = 0;

  bit o_gate [64];
  bit o_step [64];
  bit o_done [64];
  bit o_busy [64];
  int o_addr [64];
  int o_note [64];

  tone_sequencer #(
    .IDX_W(IDX_W), .SEQ_LEN(SEQ_LEN), .DUR_W(DUR_W), .TICK_W(TICK_W), .GAP_EN(GAP_EN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i), .pause_i(pause_i),
    .loop_i(loop_i), .tempo_i(tempo_i), .seq_addr_o(seq_addr_o), .seq_data_i(seq_data_i),
    .note_index_o(note_index_o), .gate_o(gate_o), .busy_o(busy_o), .step_o(step_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  always_comb seq_data_i = mem[seq_addr_o[1:0]];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] ent(input int r, input int d, input int n);
    logic [10:0] e;
    e = {1'(r), 4'(d), 6'(n)};
    return e;
  endfunction

  task automatic m_end();
    if (loop_i) begin
      m_addr  = '0;
      m_phase = 1;
    end else begin
      m_phase = 4;
    end
  endtask

  task automatic m_advance();
    if (int'(m_addr) == SEQ_LEN - 1) m_end();
    else begin
      m_addr  = m_addr + 6'd1;
      m_phase = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_addr = '0; m_note = '0; m_rest = 1'b0; m_left = 0;
    end else begin
      int t;
      logic [10:0] e;
      t = (tempo_i == 0) ? 1 : int'(tempo_i);
      if (stop_i) begin
        m_phase = 0;
        m_addr  = '0;
      end else begin
        case (m_phase)
          0: if (start_i) begin m_phase = 1; m_addr = '0; end
          1: begin
            e      = mem[m_addr[1:0]];
            m_note = e[5:0];
            m_rest = e[10];
            if (e[10] && e[5:0] == 6'h3f) m_end();
            else begin
              m_phase = 2;
              m_left  = (int'(e[9:6]) + 1) * t;
            end
          end
          2: if (!pause_i) begin
            m_left--;
            if (m_left == 0) begin
              if (GAP_EN != 0) begin m_phase = 3; m_left = t; end
              else m_advance();
            end
          end
          3: if (!pause_i) begin
            m_left--;
            if (m_left == 0) m_advance();
          end
          default: begin m_phase = 0; m_addr = '0; end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy_o, int'(m_phase != 0));
    chk("step", step_o, int'(m_phase == 1));
    chk("done", done_o, int'(m_phase == 4));
    chk("gate", gate_o, int'((m_phase == 2) && !m_rest && !pause_i));
    chk("addr", seq_addr_o, m_addr);
    chk("note", note_index_o, m_note);
  end

  task automatic observe(input int n, input int s1, input int s2, input int sp,
                         input int pf, input int pl, input int lo);
    for (int k = 0; k <= n; k++) begin
      @(posedge clk); #2;
      start_i = (k == s1) || (k == s2);
      stop_i  = (k == sp);
      pause_i = (k >= pf) && (k < pf + pl);
      if (k == lo) loop_i = 1'b0;
      @(negedge clk);
      o_gate[k] = gate_o; o_step[k] = step_o; o_done[k] = done_o;
      o_busy[k] = busy_o; o_addr[k] = seq_addr_o; o_note[k] = note_index_o;
    end
    @(posedge clk); #2;
    start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0;
  endtask

  function automatic int nth_step(input int which, input int n);
    int c = 0;
    for (int k = 0; k <= n; k++) if (o_step[k]) begin
      c++;
      if (c == which) return k;
    end
    return -1;
  endfunction

  function automatic int cnt_gate(input int note, input int n);
    int c = 0;
    for (int k = 0; k <= n; k++) if (o_gate[k] && (note < 0 || o_note[k] == note)) c++;
    return c;
  endfunction

  function automatic int cnt_done(input int n);
    int c = 0;
    for (int k = 0; k <= n; k++) if (o_done[k]) c++;
    return c;
  endfunction

  function automatic int cnt_busy(input int n);
    int c = 0;
    for (int k = 0; k <= n; k++) if (o_busy[k]) c++;
    return c;
  endfunction

  function automatic int first_done(input int n);
    for (int k = 0; k <= n; k++) if (o_done[k]) return k;
    return -1;
  endfunction

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy_o && k < bound) begin @(negedge clk); k++; end
    tests++;
    if (busy_o) begin
      fails++;
      $display("FAIL wait_idle: busy_o still 1 after %0d cycles, expected 0", bound);
    end
  endtask

  task automatic load_basic();
    mem[0] = ent(0, 1, 5); mem[1] = ent(0, 0, 9);
    mem[2] = ent(1, 0, 63); mem[3] = ent(0, 0, 1);
  endtask

  initial begin
    load_basic();
    #1;
    chk("rst_busy", busy_o, 0); chk("rst_gate", gate_o, 0); chk("rst_step", step_o, 0);
    chk("rst_done", done_o, 0); chk("rst_addr", seq_addr_o, 0); chk("rst_note", note_index_o, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic sequence, tempo 3
    tempo_i = 24'd3;
    observe(26, 0, -1, -1, -1, 0, -1);
    chk("basic_step1", nth_step(1, 26), 1);
    chk("basic_step2", nth_step(2, 26), 11);
    chk("basic_step3", nth_step(3, 26), 18);
    chk("basic_done_at", first_done(26), 19);
    chk("basic_done_cnt", cnt_done(26), 1);
    chk("basic_gate5", cnt_gate(5, 26), 6);
    chk("basic_gate9", cnt_gate(9, 26), 3);
    chk("basic_idle_after", o_busy[20], 0);
    wait_idle(200);

    // Rest entry
    mem[0] = ent(1, 2, 7);
    observe(26, 0, -1, -1, -1, 0, -1);
    chk("rest_gate7", cnt_gate(7, 26), 0);
    chk("rest_note7", o_note[5], 7);
    chk("rest_gate9", cnt_gate(9, 26), 3);
    chk("rest_done_at", first_done(26), 22);
    wait_idle(200);

    // Loop with wrap, then drop loop_i
    tempo_i = 24'd1;
    mem[0] = ent(0, 0, 1); mem[1] = ent(0, 0, 2); mem[2] = ent(0, 0, 3); mem[3] = ent(0, 0, 4);
    loop_i = 1'b1;
    observe(28, 0, -1, -1, -1, 0, 14);
    for (int i = 1; i <= 5; i++) begin
      chk("loop_step_pos", nth_step(i, 28), 1 + 3 * (i - 1));
      chk("loop_step_addr", o_addr[1 + 3 * (i - 1)], (i - 1) % 4);
    end
    chk("loop_done_at", first_done(28), 25);
    chk("loop_done_cnt", cnt_done(28), 1);
    chk("loop_idle_after", o_busy[26], 0);
    wait_idle(200);

    // Pause for 10 clocks mid-PLAY
    tempo_i = 24'd4;
    mem[0] = ent(0, 2, 11); mem[1] = ent(1, 0, 63);
    observe(32, 0, -1, -1, 5, 10, -1);
    chk("pause_step2", nth_step(2, 32), 28);
    chk("pause_gate", cnt_gate(11, 32), 12);
    chk("pause_gate_in", o_gate[9], 0);
    chk("pause_done_at", first_done(32), 29);
    wait_idle(200);

    // Stop priority
    tempo_i = 24'd3;
    load_basic();
    observe(4, 0, -1, 0, -1, 0, -1);
    chk("stop_start_idle", cnt_busy(4), 0);
    observe(30, 0, -1, 4, -1, 0, -1);
    chk("stop_busy_before", o_busy[4], 1);
    chk("stop_busy", o_busy[5], 0);
    chk("stop_gate", o_gate[5], 0);
    chk("stop_addr", o_addr[5], 0);
    chk("stop_no_done", cnt_done(30), 0);
    wait_idle(200);

    // Tempo 0 ticks every clock
    tempo_i = 24'd0;
    mem[0] = ent(0, 3, 20); mem[1] = ent(1, 0, 63);
    observe(12, 0, -1, -1, -1, 0, -1);
    chk("t0_gate", cnt_gate(20, 12), 4);
    chk("t0_step2", nth_step(2, 12), 7);
    chk("t0_done_at", first_done(12), 8);
    wait_idle(200);

    // Start while busy is ignored
    tempo_i = 24'd3;
    load_basic();
    observe(26, 0, 5, -1, -1, 0, -1);
    chk("busy_start_done", first_done(26), 19);
    chk("busy_start_step4", nth_step(4, 26), -1);
    wait_idle(200);

    // Asynchronous reset mid-PLAY
    @(posedge clk); #2 start_i = 1'b1;
    @(posedge clk); #2 start_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_busy", busy_o, 0); chk("areset_gate", gate_o, 0);
    chk("areset_addr", seq_addr_o, 0); chk("areset_note", note_index_o, 0);
    chk("areset_step", step_o, 0); chk("areset_done", done_o, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Randomized runs against the model
    for (int it = 0; it < 60; it++) begin
      @(posedge clk); #2;
      tempo_i = TICK_W'($urandom_range(0, 3));
      for (int i = 0; i < SEQ_LEN; i++) begin
        int r;
        r = $urandom_range(0, 5);
        if (r == 0) mem[i] = ent(1, 0, 63);
        else mem[i] = ent(int'(r == 1), $urandom_range(0, 3), $urandom_range(0, 62));
      end
      loop_i  = 1'($urandom_range(0, 1));
      start_i = 1'b1;
      for (int c = 0; c < 150; c++) begin
        @(posedge clk); #2;
        start_i = ($urandom_range(0, 19) == 0);
        stop_i  = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 7) == 0) pause_i = ~pause_i;
        if ($urandom_range(0, 29) == 0) loop_i = ~loop_i;
      end
      @(posedge clk); #2;
      start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0; loop_i = 1'b0;
      @(negedge clk);
      wait_idle(2000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Playback controller for the tone datapath (notes ROM + PWM modulator).
- Walks a sequence memory of {rest, duration, note} entries on a tempo tick.
- Drives the note index into the notes ROM and a gate that enables the PWM output.
- Adds start/stop/pause/loop control and per-note durations.
- Replaces the free-running fixed-step sequence counter in the top level.

Parameters:
- IDX_W, 6: width of the note index and of the sequence address.
- SEQ_LEN, 64: number of sequence entries; the address range is 0..SEQ_LEN-1.
- DUR_W, 4: width of the duration field; a note lasts dur+1 ticks.
- TICK_W, 24: width of the tempo counter and of tempo_i.
- GAP_EN, 1: 1 inserts a one-tick silent gap after every entry; 0 means no gap.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start_i, input, 1: single-cycle request to begin playback at address 0.
- stop_i, input, 1: abort playback; has priority over every other input.
- pause_i, input, 1: level; while high, state and tick counter are frozen.
- loop_i, input, 1: level; sampled at end of sequence.
- tempo_i, input, TICK_W: tick period in clocks; 0 is treated as 1.
- seq_addr_o, output, IDX_W: address into the sequence memory.
- seq_data_i, input, 1+DUR_W+IDX_W: combinational read data {rest, dur, note}, valid in the same cycle as the address.
- note_index_o, output, IDX_W: note index to the notes ROM.
- gate_o, output, 1: 1 enables the PWM output.
- busy_o, output, 1: 1 in every state except IDLE.
- step_o, output, 1: one-cycle pulse on each entry fetch.
- done_o, output, 1: one-cycle pulse at normal, non-looping completion.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; seq_addr_o=0; note_index_o=0; tick counter=0.
  - gate_o, busy_o, step_o, done_o all 0.
- FSM states: IDLE, FETCH, PLAY, GAP, DONE.
- IDLE:
  - start_i=1 and stop_i=0 -> FETCH; seq_addr_o=0; tick counter cleared.
  - Otherwise stay; gate_o=0.
- FETCH (exactly 1 cycle):
  - Latch seq_data_i: note_index_o<=note, dur_cnt<=dur, rest flag<=rest.
  - step_o=1 during this cycle.
  - End marker is note == all-ones with rest=1. On end marker: go to the END decision, no PLAY.
  - Otherwise -> PLAY.
- Tick generation:
  - Counter runs only in PLAY/GAP with pause_i=0.
  - tick=1 when counter == max(tempo_i,1)-1; counter then wraps to 0.
  - Counter is cleared on entry to FETCH.
- PLAY:
  - gate_o = ~rest & ~pause_i.
  - On tick: if dur_cnt==0 -> GAP (GAP_EN=1) or ADVANCE (GAP_EN=0); else dur_cnt-=1.
  - Total PLAY length is (dur+1)*max(tempo_i,1) clocks when not paused.
- GAP:
  - gate_o=0; one tick long, then ADVANCE.
- ADVANCE (combinational, resolved in the same edge):
  - If seq_addr_o == SEQ_LEN-1 -> END decision.
  - Else seq_addr_o+=1 -> FETCH.
- END decision:
  - loop_i=1 -> seq_addr_o=0 -> FETCH.
  - loop_i=0 -> DONE.
- DONE (1 cycle):
  - done_o=1, gate_o=0 -> IDLE.
  - seq_addr_o is reset to 0 on entering IDLE.
- stop_i=1 in any state:
  - Next state IDLE; seq_addr_o=0; gate_o=0 next cycle; no done_o pulse.
- start_i while busy_o=1: ignored.
- pause_i:
  - Freezes the state, dur_cnt and tick counter; gate_o forced 0.
  - FETCH and DONE complete even if pause_i rises in that cycle.
- tempo_i change mid-note: takes effect at the next counter compare; no glitch handling beyond the wrap rule.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous).

Test Plan:
- Basic sequence:
  - Stimulus: reset; tempo_i=3; GAP_EN=1; memory {0,1,5},{0,0,9},{1,0,63}; pulse start_i.
  - Required: step_o at cycle 1; note 5 with gate high for 6 clocks; gate low 3 clocks; note 9 with gate high 3 clocks; gate low 3 clocks; end marker fetch; done_o pulse; busy_o=0.
- Rest entry:
  - Stimulus: entry {1,2,7}.
  - Required: note_index_o=7 but gate_o=0 for 9 clocks; sequence continues.
- Loop with wrap:
  - Stimulus: SEQ_LEN=4, no end marker, loop_i=1.
  - Required: seq_addr_o goes 0,1,2,3,0; no done_o.
  - Stimulus: drop loop_i.
  - Required: after entry 3, done_o=1 for one cycle.
- Pause:
  - Stimulus: tempo_i=4; assert pause_i for 10 clocks mid-PLAY.
  - Required: gate_o=0 during the pause; remaining note length unchanged after release; total PLAY time = 4*(dur+1)+10.
- Stop priority:
  - Stimulus: start_i and stop_i together in IDLE.
  - Required: stays IDLE.
  - Stimulus: stop_i during PLAY.
  - Required: next cycle IDLE, gate_o=0, seq_addr_o=0, no done_o.
- Edge cases:
  - Stimulus: tempo_i=0.
  - Required: tick every clock.
  - Stimulus: rst_n low mid-PLAY.
  - Required: all outputs 0 without a clock edge.
  - Stimulus: start_i pulse while busy.
  - Required: no restart.
